hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline control block that drives the write-enable, flush and bubble inputs around the IF/ID and ID/EX pipeline registers.
- Watches the instruction in ID and the instruction in EX, and decides each cycle whether to:
  - freeze the pipe for a multi-cycle EX unit,
  - flush the pipe after a taken branch, or
  - insert load-use bubbles into ID/EX.
- A small FSM holds load-use stalls for a configurable data-memory latency.
- Saturating stall/flush counters provide performance monitoring.

Parameters:
LOAD_STALLS, 1, bubbles inserted per load-use hazard (legal 1..15)
CNT_W, 16, width of the performance counters

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rs1_id  input  5  source register 1 of the instruction in ID
rs2_id  input  5  source register 2 of the instruction in ID
uses_rs1_id  input  1  the instruction in ID reads rs1
uses_rs2_id  input  1  the instruction in ID reads rs2
rd_ex  input  5  destination register of the instruction in EX
MemRead_ex  input  1  the instruction in EX is a load
branch_taken_ex  input  1  branch resolved taken in EX this cycle
ex_busy  input  1  multi-cycle EX unit is not done
counter_clear  input  1  synchronous clear of both counters
pc_write  output  1  PC may update
if_id_write  output  1  IF/ID register may load
if_id_flush  output  1  IF/ID loads a NOP
id_ex_write  output  1  ID/EX register may load
id_ex_bubble  output  1  ID/EX loads all control signals as 0
stall_active  output  1  FSM is in LOAD_STALL
stall_count  output  CNT_W  cycles with any stall or bubble asserted
flush_count  output  CNT_W  number of taken-branch flushes

Behaviour:
- Load-use hazard (combinational):
  - hz = MemRead_ex & (rd_ex != 0) & ((uses_rs1_id & rs1_id == rd_ex) | (uses_rs2_id & rs2_id == rd_ex)).
  - x0 never causes a hazard.
- FSM has two states, RUN and LOAD_STALL.
- Down-counter rem, 4 bits.
- Control outputs are combinational from state and inputs, so the decision takes effect in the same cycle.
- Priority, evaluated every cycle (highest first):
  1. ex_busy = 1:
     - pc_write = if_id_write = id_ex_write = 0; id_ex_bubble = 0; if_id_flush = 0.
     - State and rem are held; branch_taken_ex is ignored.
  2. branch_taken_ex = 1:
     - pc_write = 1, if_id_write = 1, if_id_flush = 1, id_ex_write = 1, id_ex_bubble = 1.
     - Next state is RUN, rem = 0.
     - Also aborts a LOAD_STALL in progress.
  3. State LOAD_STALL:
     - pc_write = 0, if_id_write = 0, id_ex_write = 1, id_ex_bubble = 1.
     - If rem == 1, go to RUN; otherwise rem decrements.
  4. State RUN with hz = 1:
     - Same outputs as LOAD_STALL (first bubble cycle).
     - If LOAD_STALLS == 1, stay in RUN.
     - Otherwise go to LOAD_STALL with rem = LOAD_STALLS-1.
  5. Otherwise, normal flow:
     - pc_write = if_id_write = id_ex_write = 1.
     - if_id_flush = id_ex_bubble = 0.
- stall_active = (state == LOAD_STALL).
- Counters:
  - stall_count increments in any cycle where pc_write == 0 or id_ex_bubble == 1.
  - flush_count increments in any cycle where priority 2 fires.
  - Both saturate at all-ones and never wrap.
  - counter_clear forces both counters to 0 next cycle and takes priority over increment.
- Reset (asynchronous, any cycle including mid-stall):
  - State = RUN, rem = 0, both counters = 0.
  - Outputs then follow the RUN rules: pc_write = if_id_write = id_ex_write = 1, if_id_flush = id_ex_bubble = 0, stall_active = 0.

Decomposition:
- Shared package pipeline_pkg holds:
  - the state encoding (RUN = 1'b0, LOAD_STALL = 1'b1);
  - the REG_ZERO constant 5'd0;
  - the register-index width 5.
- One natural sub-module: sat_counter (parameter W, with inc, clr and count), instantiated twice.

Test Plan:
- Load-use, default LOAD_STALLS=1: MemRead_ex=1, rd_ex=5, rs1_id=5, uses_rs1_id=1 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (rd_ex=0) all enables 1; stall_count=1.
- Register x0: MemRead_ex=1, rd_ex=0, rs1_id=0, uses_rs1_id=1 -> no stall, stall_count stays 0. Repeat with rs2 match but uses_rs2_id=0 -> no stall.
- LOAD_STALLS=3 with hz for one cycle -> exactly 3 consecutive bubble cycles; stall_active=1 in cycles 2-3; back to RUN; stall_count=3.
- Branch during stall: LOAD_STALLS=3, assert branch_taken_ex in the 2nd bubble cycle -> that cycle if_id_flush=1, pc_write=1; next cycle normal flow; flush_count=1, stall_count=2.
- ex_busy held 4 cycles, overlapping branch_taken_ex=1 and hz=1 -> all writes 0, no flush; flush_count unchanged; stall_count +4. Hazard is then handled after ex_busy drops.
- Saturation, clear and reset: CNT_W=2, 5 stall cycles -> stall_count=3. Then:
  - counter_clear together with a stall cycle -> 0.
  - reset pulse asserted mid-LOAD_STALL -> state RUN and all enables 1 immediately, without waiting for a clock.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall control slice:
// register-index width, the x0 constant, the stall FSM encoding and
// the load-use hazard detector shared by any block that needs it.
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_t;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is hard-wired to zero, so writes to it never create a dependency.
  function automatic logic load_use_hazard(
    input logic             mem_read,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic             use1,
    input logic             use2
  );
    logic match1;
    logic match2;
    match1 = use1 && (rs1 == rd);
    match2 = use2 && (rs2 == rd);
    return mem_read && (rd != REG_ZERO) && (match1 || match2);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. Holds at all-ones
// instead of wrapping so a long run never reports a small count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = '1;

  // Clear wins over increment; increment stops at the maximum value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline control for the IF/ID and ID/EX registers. Each cycle it
// decides between freezing for a busy multi-cycle EX unit, flushing on
// a taken branch, inserting load-use bubbles, or letting the pipe flow.
// Decisions are combinational so they act in the cycle they are made;
// only the load-use stall sequencing and the perf counters hold state.
module hazard_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             MemRead_ex,
  input  logic             branch_taken_ex,
  input  logic             ex_busy,
  input  logic             counter_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Bubbles still owed after the first one, which is issued from RUN.
  localparam logic [3:0] REM_INIT = 4'(LOAD_STALLS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] rem;
  logic [3:0] rem_nxt;
  logic       hz;
  logic       flush_fire;
  logic       stall_inc;

  assign hz = load_use_hazard(MemRead_ex, rd_ex, rs1_id, rs2_id,
                              uses_rs1_id, uses_rs2_id);

  // Stall FSM state and remaining-bubble counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      rem   <= 4'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Prioritised control decision: busy > branch > ongoing stall > new hazard > flow.
  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    flush_fire   = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;

    if (ex_busy) begin
      // Freeze everything; a branch or hazard is re-evaluated once EX finishes.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else if (branch_taken_ex) begin
      // Younger instructions are on the wrong path, so any pending stall is moot.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_fire   = 1'b1;
      state_nxt    = RUN;
      rem_nxt      = 4'd0;
    end else if (state == LOAD_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      rem_nxt      = rem - 4'd1;
      if (rem == 4'd1) begin
        state_nxt = RUN;
      end
    end else if (hz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_STALLS != 1) begin
        state_nxt = LOAD_STALL;
        rem_nxt   = REM_INIT;
      end
    end
  end

  assign stall_active = (state == LOAD_STALL);
  assign stall_inc    = ~pc_write | id_ex_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (counter_clear),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_fire),
    .clr   (counter_clear),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: instance A uses the defaults
// (LOAD_STALLS=1, CNT_W=16), instance B uses LOAD_STALLS=3, CNT_W=2.
// Both share the stimulus; each test starts from reset and checks the
// instance it targets.
module tb_hazard_stall_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       uses_rs1_id, uses_rs2_id, MemRead_ex;
  logic       branch_taken_ex, ex_busy, counter_clear;

  logic        pc_a, ifw_a, iff_a, idw_a, bub_a, sa_a;
  logic [15:0] scnt_a, fcnt_a;
  logic        pc_b, ifw_b, iff_b, idw_b, bub_b, sa_b;
  logic [1:0]  scnt_b, fcnt_b;
  logic [5:0]  ctl_a, ctl_b;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, stall_active}
  localparam logic [5:0] NORMAL   = 6'b110100;
  localparam logic [5:0] BUB_RUN  = 6'b000110;
  localparam logic [5:0] BUB_STL  = 6'b000111;
  localparam logic [5:0] BR_RUN   = 6'b111110;
  localparam logic [5:0] BR_STL   = 6'b111111;
  localparam logic [5:0] FROZEN   = 6'b000000;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [5:0] v;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic       hz;
  } vec_t;
  vec_t vecs[8];

  always #5 clock = ~clock;

  hazard_stall_ctrl u_a (
    .clock(clock), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
    .MemRead_ex(MemRead_ex), .branch_taken_ex(branch_taken_ex),
    .ex_busy(ex_busy), .counter_clear(counter_clear),
    .pc_write(pc_a), .if_id_write(ifw_a), .if_id_flush(iff_a),
    .id_ex_write(idw_a), .id_ex_bubble(bub_a), .stall_active(sa_a),
    .stall_count(scnt_a), .flush_count(fcnt_a)
  );

  hazard_stall_ctrl #(.LOAD_STALLS(3), .CNT_W(2)) u_b (
    .clock(clock), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
    .MemRead_ex(MemRead_ex), .branch_taken_ex(branch_taken_ex),
    .ex_busy(ex_busy), .counter_clear(counter_clear),
    .pc_write(pc_b), .if_id_write(ifw_b), .if_id_flush(iff_b),
    .id_ex_write(idw_b), .id_ex_bubble(bub_b), .stall_active(sa_b),
    .stall_count(scnt_b), .flush_count(fcnt_b)
  );

  assign ctl_a = {pc_a, ifw_a, iff_a, idw_a, bub_a, sa_a};
  assign ctl_b = {pc_b, ifw_b, iff_b, idw_b, bub_b, sa_b};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic exp_ctl(input string nm, input logic [5:0] v);
    sb_t e;
    e.name = nm;
    e.v    = v;
    sbq.push_back(e);
  endtask

  task automatic chk_ctl(input logic [5:0] got);
    sb_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %b expected an entry", got);
    end else begin
      e = sbq.pop_front();
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL %s: got ctl %b expected %b", e.name, got, e.v);
      end
    end
  endtask

  task automatic idle();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; MemRead_ex = 1'b0;
    branch_taken_ex = 1'b0; ex_busy = 1'b0; counter_clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Hazard on rd=5 through rs1.
  task automatic set_hz();
    MemRead_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; uses_rs1_id = 1'b1;
  endtask

  initial begin
    vecs[0] = '{"hz_rs1",        1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1};
    vecs[1] = '{"x0_rs1",        1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{"rs2_unused",    1'b1, 5'd7,  5'd0,  5'd7,  1'b0, 1'b0, 1'b0};
    vecs[3] = '{"hz_rs2",        1'b1, 5'd7,  5'd0,  5'd7,  1'b0, 1'b1, 1'b1};
    vecs[4] = '{"not_load",      1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0};
    vecs[5] = '{"no_match",      1'b1, 5'd5,  5'd4,  5'd6,  1'b1, 1'b1, 1'b0};
    vecs[6] = '{"hz_r31_rs2",    1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{"x0_rs2",        1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0};

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state on both instances.
    exp_ctl("reset_ctl_a", NORMAL);
    exp_ctl("reset_ctl_b", NORMAL);
    #3;
    chk_ctl(ctl_a);
    chk_ctl(ctl_b);
    chk("reset_scnt_a", 32'(scnt_a), 32'd0);
    chk("reset_fcnt_a", 32'(fcnt_a), 32'd0);
    tick();

    // Single load-use bubble with LOAD_STALLS=1.
    do_reset();
    set_hz();
    exp_ctl("ls1_bubble", BUB_RUN);
    #3; chk_ctl(ctl_a); tick();
    idle();
    exp_ctl("ls1_after", NORMAL);
    #3; chk_ctl(ctl_a);
    chk("ls1_scnt", 32'(scnt_a), 32'd1);
    tick();

    // Hazard detection table on instance A.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      MemRead_ex  = vecs[i].mr;
      rd_ex       = vecs[i].rd;
      rs1_id      = vecs[i].rs1;
      rs2_id      = vecs[i].rs2;
      uses_rs1_id = vecs[i].u1;
      uses_rs2_id = vecs[i].u2;
      exp_ctl(vecs[i].name, vecs[i].hz ? BUB_RUN : NORMAL);
      #3; chk_ctl(ctl_a); tick();
    end
    idle();
    #3;
    chk("table_scnt", 32'(scnt_a), 32'd3);
    tick();

    // LOAD_STALLS=3: three bubbles, FSM busy in cycles 2-3.
    do_reset();
    set_hz();
    exp_ctl("ls3_c1", BUB_RUN);
    #3; chk_ctl(ctl_b); tick();
    idle();
    exp_ctl("ls3_c2", BUB_STL);
    #3; chk_ctl(ctl_b); tick();
    exp_ctl("ls3_c3", BUB_STL);
    #3; chk_ctl(ctl_b); tick();
    exp_ctl("ls3_c4", NORMAL);
    #3; chk_ctl(ctl_b);
    chk("ls3_scnt", 32'(scnt_b), 32'd3);
    tick();

    // Taken branch aborts the stall in the second bubble cycle.
    do_reset();
    set_hz();
    exp_ctl("br_c1", BUB_RUN);
    #3; chk_ctl(ctl_b); tick();
    idle();
    branch_taken_ex = 1'b1;
    exp_ctl("br_c2", BR_STL);
    #3; chk_ctl(ctl_b); tick();
    idle();
    exp_ctl("br_c3", NORMAL);
    #3; chk_ctl(ctl_b);
    chk("br_fcnt", 32'(fcnt_b), 32'd1);
    chk("br_scnt", 32'(scnt_b), 32'd2);
    tick();

    // Branch from RUN on instance A.
    do_reset();
    branch_taken_ex = 1'b1;
    exp_ctl("br_run", BR_RUN);
    #3; chk_ctl(ctl_a); tick();
    idle();
    #3;
    chk("br_run_fcnt", 32'(fcnt_a), 32'd1);
    tick();

    // ex_busy freezes over a pending branch and hazard.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ex_busy = 1'b1; branch_taken_ex = 1'b1; set_hz();
      exp_ctl("busy_frozen", FROZEN);
      #3; chk_ctl(ctl_a); tick();
    end
    ex_busy = 1'b0; branch_taken_ex = 1'b0;
    exp_ctl("busy_then_hz", BUB_RUN);
    #3; chk_ctl(ctl_a); tick();
    idle();
    exp_ctl("busy_after", NORMAL);
    #3; chk_ctl(ctl_a);
    chk("busy_fcnt", 32'(fcnt_a), 32'd0);
    chk("busy_scnt", 32'(scnt_a), 32'd5);
    tick();

    // Saturation at CNT_W=2, then clear during a stall cycle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ex_busy = 1'b1;
      #3; tick();
    end
    counter_clear = 1'b1;
    #3;
    chk("sat_scnt", 32'(scnt_b), 32'd3);
    tick();
    counter_clear = 1'b0;
    ex_busy = 1'b0;
    #3;
    chk("clr_scnt", 32'(scnt_b), 32'd0);
    tick();

    // Asynchronous reset in the middle of a LOAD_STALL.
    set_hz();
    exp_ctl("rst_c1", BUB_RUN);
    #3; chk_ctl(ctl_b); tick();
    idle();
    exp_ctl("rst_c2", BUB_STL);
    #3; chk_ctl(ctl_b);
    reset = 1'b1;
    #1;
    exp_ctl("rst_async", NORMAL);
    chk_ctl(ctl_b);
    chk("rst_scnt", 32'(scnt_b), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    exp_ctl("rst_after", NORMAL);
    #3; chk_ctl(ctl_b);
    tick();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
